// File: rtl/quant_pkg.sv
// Shared types and constants for the block quantizer datapath.
package quant_pkg;
  localparam int QFIX_DEF      = 17;
  localparam int MAX_LEVEL_DEF = 2047;
  localparam int BLK_COEFFS    = 16;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] iq;
    logic [31:0] bias;
    logic [31:0] zthresh;
  } quant_set_t;

  // Clamp a signed value into a w-bit two's complement range.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction
endpackage

// File: rtl/quantize_lane.sv
// One coefficient lane: stage 1 reciprocal multiply/clamp/threshold, stage 2 dequant and error.
module quantize_lane import quant_pkg::*; #(
  parameter int QFIX      = QFIX_DEF,
  parameter int MAX_LEVEL = MAX_LEVEL_DEF,
  parameter int ERR_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic [15:0]             coeff_i,
  input  quant_set_t              qs_i,
  input  logic [15:0]             sharp_i,
  output logic signed [11:0]      level_o,
  output logic signed [15:0]      deq_o,
  output logic signed [ERR_W-1:0] err_o
);
  logic [16:0] v, vs;
  logic [32:0] t;
  logic [10:0] lmag;
  logic        zero;

  logic        sign_q, zero_q;
  logic [15:0] in_q, q_q;
  logic [10:0] lmag_q;

  // V is 17 bits wide so -32768 maps cleanly to +32768.
  always_comb begin
    v    = coeff_i[15] ? 17'd0 - {1'b1, coeff_i} : {1'b0, coeff_i};
    vs   = v + {1'b0, sharp_i};
    t    = (33'(vs) * 33'(qs_i.iq) + 33'(qs_i.bias)) >> QFIX;
    lmag = (t > 33'(MAX_LEVEL)) ? 11'(MAX_LEVEL) : t[10:0];
    zero = 32'(v) <= qs_i.zthresh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      in_q   <= '0;
      q_q    <= '0;
      lmag_q <= '0;
    end else if (en_i) begin
      sign_q <= coeff_i[15];
      zero_q <= zero;
      in_q   <= coeff_i;
      q_q    <= qs_i.q;
      lmag_q <= lmag;
    end
  end

  logic [10:0]             mag;
  logic [26:0]             dprod;
  logic [14:0]             dmag;
  logic signed [11:0]      level_d;
  logic signed [15:0]      deq_d;
  logic signed [17:0]      diff;
  logic signed [31:0]      err32;
  logic signed [ERR_W-1:0] err_d;

  // A zeroed coefficient has deq 0, so the error path needs no special case.
  always_comb begin
    mag     = zero_q ? '0 : lmag_q;
    dprod   = 27'(mag) * 27'(q_q);
    dmag    = (dprod > 27'd32767) ? 15'h7fff : dprod[14:0];
    level_d = sign_q ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    deq_d   = sign_q ? -$signed({1'b0, dmag}) : $signed({1'b0, dmag});
    diff    = $signed({{2{in_q[15]}}, in_q}) - $signed({{2{deq_d[15]}}, deq_d});
    err32   = 32'(diff >>> 1);
    err_d   = ERR_W'(sat_signed(err32, ERR_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_o <= '0;
      deq_o   <= '0;
      err_o   <= '0;
    end else if (en_i) begin
      level_o <= level_d;
      deq_o   <= deq_d;
      err_o   <= err_d;
    end
  end
endmodule

// File: rtl/quantize_block_pipe.sv
// 4x4 block quantizer, LANES coefficients per beat, two-stage valid/ready pipeline.
// Optional AC sharpening enabled by defining QUANT_SHARPEN_EN.
module quantize_block_pipe import quant_pkg::*; #(
  parameter int LANES     = 4,
  parameter int QFIX      = QFIX_DEF,
  parameter int MAX_LEVEL = MAX_LEVEL_DEF,
  parameter int ERR_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*16-1:0]    in_coeff,
  input  logic [15:0]            q_dc,
  input  logic [15:0]            q_ac,
  input  logic [15:0]            iq_dc,
  input  logic [15:0]            iq_ac,
  input  logic [31:0]            bias_dc,
  input  logic [31:0]            bias_ac,
  input  logic [31:0]            zthresh_dc,
  input  logic [31:0]            zthresh_ac,
  input  logic [15:0]            sharpen_ac,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*12-1:0]    out_level,
  output logic [LANES*16-1:0]    out_deq,
  output logic [LANES*ERR_W-1:0] out_err,
  output logic                   out_last,
  output logic                   blk_nz,
  output logic [3:0]             blk_last_nz
);
  localparam int NBEATS = BLK_COEFFS / LANES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int STAGES = 2;

  logic          en, accept, first, last;
  logic [BW-1:0] beat_q, beat_s1_q, beat_s2_q;
  logic          last_s1_q, last_s2_q;
  logic [STAGES:1] vld_pipe_q;
  quant_set_t    dc_q, ac_q, cur_dc, cur_ac;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign accept    = in_valid && en;
  assign first     = (beat_q == '0);
  assign last      = (beat_q == BW'(NBEATS - 1));
  assign out_valid = vld_pipe_q[STAGES];
  assign out_last  = vld_pipe_q[STAGES] && last_s2_q;

  // Beat 0 sees the live parameter ports; later beats use the captured copy.
  assign cur_dc = first ? quant_set_t'{q_dc, iq_dc, bias_dc, zthresh_dc} : dc_q;
  assign cur_ac = first ? quant_set_t'{q_ac, iq_ac, bias_ac, zthresh_ac} : ac_q;

`ifdef QUANT_SHARPEN_EN
  logic [15:0] sharp_q, cur_sharp;
  assign cur_sharp = first ? sharpen_ac : sharp_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                sharp_q <= '0;
    else if (accept && first)  sharp_q <= sharpen_ac;
  end
`else
  logic unused_sharpen;
  assign unused_sharpen = ^sharpen_ac;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      dc_q   <= '0;
      ac_q   <= '0;
    end else if (accept) begin
      beat_q <= last ? '0 : beat_q + 1'b1;
      if (first) begin
        dc_q <= cur_dc;
        ac_q <= cur_ac;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      beat_s1_q  <= '0;
      beat_s2_q  <= '0;
      last_s1_q  <= 1'b0;
      last_s2_q  <= 1'b0;
    end else if (en) begin
      vld_pipe_q <= {vld_pipe_q[1], in_valid};
      beat_s1_q  <= beat_q;
      beat_s2_q  <= beat_s1_q;
      last_s1_q  <= last;
      last_s2_q  <= last_s1_q;
    end
  end

  logic [LANES-1:0][15:0]      coeff, deq;
  logic [LANES-1:0][11:0]      lvl;
  logic [LANES-1:0][ERR_W-1:0] err;

  assign coeff     = in_coeff;
  assign out_level = lvl;
  assign out_deq   = deq;
  assign out_err   = err;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    quant_set_t  qs;
    logic [15:0] sh;
    always_comb begin
      qs = (l == 0 && first) ? cur_dc : cur_ac;
      sh = '0;
`ifdef QUANT_SHARPEN_EN
      if (!(l == 0 && first)) sh = cur_sharp;
`endif
    end

    quantize_lane #(.QFIX(QFIX), .MAX_LEVEL(MAX_LEVEL), .ERR_W(ERR_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en),
      .coeff_i (coeff[l]),
      .qs_i    (qs),
      .sharp_i (sh),
      .level_o (lvl[l]),
      .deq_o   (deq[l]),
      .err_o   (err[l])
    );
  end

  // Summary = accumulated earlier beats merged with the beat currently presented.
  logic       beat_nz, cur_nz, nz_acc_q;
  logic [3:0] beat_hi, hi_acc_q;

  always_comb begin
    beat_nz = 1'b0;
    beat_hi = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lvl[l] != '0) begin
        beat_nz = 1'b1;
        beat_hi = 4'(int'(beat_s2_q) * LANES + l);
      end
    end
  end

  assign cur_nz      = out_valid && beat_nz;
  assign blk_nz      = nz_acc_q || cur_nz;
  assign blk_last_nz = cur_nz ? beat_hi : hi_acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_acc_q <= 1'b0;
      hi_acc_q <= '0;
    end else if (out_valid && out_ready) begin
      nz_acc_q <= last_s2_q ? 1'b0 : blk_nz;
      hi_acc_q <= last_s2_q ? '0 : blk_last_nz;
    end
  end
endmodule

// File: tb/tb_quantize_block_pipe.sv
// Randomized bench for quantize_block_pipe against a per-coefficient arithmetic model.
module tb_quantize_block_pipe;
  localparam int LANES = 4;
  localparam int ERR_W = 8;
  localparam int QF    = 17;
  localparam int MAXL  = 2047;

  logic                   clk = 1'b0, rst_n = 1'b0;
  logic                   in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [LANES*16-1:0]    in_coeff = '0;
  logic [15:0]            q_dc = '0, q_ac = '0, iq_dc = '0, iq_ac = '0, sharpen_ac = '0;
  logic [31:0]            bias_dc = '0, bias_ac = '0, zthresh_dc = '0, zthresh_ac = '0;
  logic [LANES*12-1:0]    out_level;
  logic [LANES*16-1:0]    out_deq;
  logic [LANES*ERR_W-1:0] out_err;
  logic                   out_last, blk_nz;
  logic [3:0]             blk_last_nz;

  always #5 clk = ~clk;

  quantize_block_pipe #(.LANES(LANES), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff),
    .q_dc(q_dc), .q_ac(q_ac), .iq_dc(iq_dc), .iq_ac(iq_ac), .bias_dc(bias_dc), .bias_ac(bias_ac),
    .zthresh_dc(zthresh_dc), .zthresh_ac(zthresh_ac), .sharpen_ac(sharpen_ac),
    .out_valid(out_valid), .out_ready(out_ready), .out_level(out_level), .out_deq(out_deq),
    .out_err(out_err), .out_last(out_last), .blk_nz(blk_nz), .blk_last_nz(blk_last_nz)
  );

  typedef struct packed {
    logic [15:0] qd, iqd; logic [31:0] bd, zd;
    logic [15:0] qa, iqa; logic [31:0] ba, za;
    logic [15:0] sh;
  } prm_t;
  typedef struct packed { prm_t p; logic [3:0][15:0] c; } stim_t;
  typedef struct packed {
    logic [3:0][11:0] lvl; logic [3:0][15:0] dq; logic [3:0][7:0] er;
    logic last, nz; logic [3:0] hi;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    total = 0, bad = 0;
  int    mb = 0, m_hi = 0;
  bit    m_nz = 0;
  int    rdy_mode = 0;
  bit    vld_rand = 0, hold_in = 0, stalled_prev = 0;
  logic [1:0] acc_hist = '0, rdy_hist = '0;
  logic [LANES*12-1:0]    p_lvl;
  logic [LANES*16-1:0]    p_deq;
  logic [LANES*ERR_W-1:0] p_err;
  logic p_last, p_nz, p_valid;
  logic [3:0] p_hi;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: straight arithmetic on one coefficient at block index k.
  function automatic void qmodel(input int c, input int k, input prm_t p,
                                 output int lvl, output int dq, output int er);
    longint v, vs, t, zt;
    int mag, q, d;
    bit dc;
    dc = (k == 0);
    v  = (c < 0) ? -c : c;
    vs = v;
`ifdef QUANT_SHARPEN_EN
    if (!dc) vs = v + longint'(p.sh);
`endif
    t  = ((vs * longint'(dc ? p.iqd : p.iqa) + longint'(dc ? p.bd : p.ba)) & ((64'sd1 <<< 33) - 1)) >>> QF;
    if (t > MAXL) t = MAXL;
    zt  = longint'(dc ? p.zd : p.za);
    mag = (v <= zt) ? 0 : int'(t);
    q   = int'(dc ? p.qd : p.qa);
    d   = mag * q;
    if (d > 32767) d = 32767;
    lvl = (c < 0) ? -mag : mag;
    dq  = (c < 0) ? -d : d;
    er  = (c - dq) >>> 1;
    if (er > 127)  er = 127;
    if (er < -128) er = -128;
  endfunction

  function automatic void model_accept(input stim_t s);
    exp_t e;
    int lv, dv, ev, k;
    e = '0;
    for (int l = 0; l < LANES; l++) begin
      k = mb * LANES + l;
      qmodel(int'($signed(s.c[l])), k, s.p, lv, dv, ev);
      e.lvl[l] = 12'(lv);
      e.dq[l]  = 16'(dv);
      e.er[l]  = 8'(ev);
      if (lv != 0) begin m_nz = 1; m_hi = k; end
    end
    e.last = (mb == 16 / LANES - 1);
    e.nz   = m_nz;
    e.hi   = 4'(m_hi);
    if (e.last) begin m_nz = 0; m_hi = 0; end
    mb = (mb + 1) % (16 / LANES);
    exp_q.push_back(e);
  endfunction

  task automatic drive(input stim_t s);
    in_coeff = s.c;
    if (mb == 0) begin
      {q_dc, iq_dc, bias_dc, zthresh_dc} = {s.p.qd, s.p.iqd, s.p.bd, s.p.zd};
      {q_ac, iq_ac, bias_ac, zthresh_ac} = {s.p.qa, s.p.iqa, s.p.ba, s.p.za};
      sharpen_ac = s.p.sh;
    end else begin
      // Mid-block parameter noise must be ignored.
      {q_dc, iq_dc, q_ac, iq_ac, sharpen_ac} = {$urandom, $urandom, 16'($urandom)};
      {bias_dc, bias_ac, zthresh_dc, zthresh_ac} = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic cycle();
    bit acc, xf;
    exp_t e;
    @(negedge clk);
    if (stim_q.size() > 0 && !hold_in && (!vld_rand || $urandom_range(0, 3) != 0)) begin
      in_valid = 1'b1;
      drive(stim_q[0]);
    end else begin
      in_valid = 1'b0;
      in_coeff = {$urandom, $urandom};
    end
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
    #1;
    chk("in_ready", in_ready, !out_valid || out_ready);
    if (rdy_hist == 2'b11) chk("latency", out_valid, acc_hist[1]);
    if (stalled_prev) begin
      chk("hold_valid", out_valid, p_valid);
      chk("hold_level", out_level, p_lvl);
      chk("hold_deq",   out_deq, p_deq);
      chk("hold_err",   out_err, p_err);
      chk("hold_last",  out_last, p_last);
      chk("hold_nz",    blk_nz, p_nz);
      chk("hold_hi",    blk_last_nz, p_hi);
    end
    xf  = out_valid && out_ready;
    acc = in_valid && in_ready;
    if (xf) begin
      if (exp_q.size() == 0) chk("spurious_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        for (int l = 0; l < LANES; l++) begin
          chk($sformatf("level%0d", l), $signed(out_level[l*12 +: 12]), $signed(e.lvl[l]));
          chk($sformatf("deq%0d", l),   $signed(out_deq[l*16 +: 16]),   $signed(e.dq[l]));
          chk($sformatf("err%0d", l),   $signed(out_err[l*8 +: 8]),     $signed(e.er[l]));
        end
        chk("out_last", out_last, e.last);
        if (e.last) begin
          chk("blk_nz", blk_nz, e.nz);
          chk("blk_last_nz", blk_last_nz, e.hi);
        end
      end
    end
    if (acc) model_accept(stim_q.pop_front());
    stalled_prev = out_valid && !out_ready;
    {p_valid, p_lvl, p_deq, p_err, p_last, p_nz, p_hi} =
      {out_valid, out_level, out_deq, out_err, out_last, blk_nz, blk_last_nz};
    acc_hist = {acc_hist[0], acc};
    rdy_hist = {rdy_hist[0], out_ready};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_last", out_last, 0);
    chk("rst_blk_nz", blk_nz, 0);
    chk("rst_blk_last_nz", blk_last_nz, 0);
    chk("rst_level", out_level, 0);
    chk("rst_err", out_err, 0);
    exp_q.delete();
    stim_q.delete();
    mb = 0; m_nz = 0; m_hi = 0;
    stalled_prev = 0; acc_hist = '0; rdy_hist = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_block(input prm_t p, input logic [15:0][15:0] cb);
    stim_t s;
    for (int b = 0; b < 16 / LANES; b++) begin
      s.p = p;
      for (int l = 0; l < LANES; l++) s.c[l] = cb[b*LANES + l];
      stim_q.push_back(s);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", stim_q.size() + exp_q.size(), 0);
  endtask

  function automatic prm_t mk(input int qd, input int iqd, input int qa, input int iqa,
                              input int za, input int sh);
    prm_t p;
    p = '0;
    p.qd = 16'(qd); p.iqd = 16'(iqd); p.qa = 16'(qa); p.iqa = 16'(iqa);
    p.za = 32'(za); p.sh = 16'(sh);
    return p;
  endfunction

  function automatic prm_t rnd_prm();
    prm_t p;
    p.qd = 16'($urandom_range(1, 64)); p.iqd = 16'($urandom_range(0, 65535));
    p.bd = $urandom_range(0, 1 << 17); p.zd = $urandom_range(0, 40);
    p.qa = 16'($urandom_range(1, 64)); p.iqa = 16'($urandom_range(0, 65535));
    p.ba = $urandom_range(0, 1 << 17); p.za = $urandom_range(0, 40);
    p.sh = 16'($urandom_range(0, 200));
    return p;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][15:0] cb;
    repeat (2) @(negedge clk);
    do_reset();

    // Sign symmetry at k=5/6.
    cb = '0; cb[5] = 16'd100; cb[6] = 16'hFF9C;
    add_block(mk(8, 16384, 8, 16384, 0, 0), cb);
    // AC zero threshold; sparse block with nonzeros at k=3 and k=9.
    cb = '0; cb[1] = 16'd5; cb[3] = 16'd100; cb[9] = 16'hFF9C;
    add_block(mk(8, 16384, 8, 16384, 10, 0), cb);
    // Level clamp and error saturation in both directions.
    cb = '0; cb[2] = 16'd32000; cb[7] = 16'h8000;
    add_block(mk(8, 16384, 4, 32768, 0, 0), cb);
    // DC/AC split.
    for (int i = 0; i < 16; i++) cb[i] = 16'd64;
    add_block(mk(16, 8192, 8, 16384, 0, 0), cb);
    // Sharpen: 60 -> 8 with sharpening, 7 without.
    for (int i = 0; i < 16; i++) cb[i] = 16'd60;
    add_block(mk(8, 16384, 8, 16384, 0, 4), cb);
    // All-zero block: no summary hit.
    cb = '0;
    add_block(mk(8, 16384, 8, 16384, 0, 0), cb);
    drain(200);

    // Five-cycle downstream stall mid-block with input pending.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) cb[i] = 16'($urandom_range(0, 2000) - 1000);
      add_block(mk(8, 16384, 8, 16384, 0, 0), cb);
    end
    repeat (3) cycle();
    rdy_mode = 1;
    repeat (5) begin
      cycle();
      chk("stall_in_ready", in_ready, 0);
    end
    rdy_mode = 0;
    drain(200);

    // Reset after two beats of a block, then a fresh block.
    for (int i = 0; i < 16; i++) cb[i] = 16'd500;
    add_block(mk(8, 16384, 8, 16384, 0, 0), cb);
    while (mb != 2) cycle();
    do_reset();
    cb = '0; cb[0] = 16'd100; cb[2] = 16'd100;
    add_block(mk(8, 16384, 8, 16384, 0, 0), cb);
    drain(100);

    // Random traffic with bubbles and backpressure.
    vld_rand = 1;
    rdy_mode = 2;
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 7))
          0:       cb[i] = 16'h8000;
          1, 2:    cb[i] = 16'($urandom);
          3:       cb[i] = '0;
          default: cb[i] = 16'($urandom_range(0, 600) - 300);
        endcase
      end
      add_block(rnd_prm(), cb);
    end
    drain(4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
